// File: rtl/cfg_pkg.sv
// Shared configuration-word layout and write-arbiter FSM encoding.
package cfg_pkg;

    localparam int CFG_W        = 35;
    localparam int TC_REF_LSB   = 0;
    localparam int CHS_CONF_LSB = 8;
    localparam int ULIGHT_LSB   = 16;
    localparam int LENGTH_LSB   = 20;
    localparam int DANCE_LSB    = 24;
    localparam int SYSKEY_LSB   = 33;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MERGE  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/config_write_arbiter.sv
// Arbitrates requesters onto the configuration memory write port with a masked
// read-modify-write, syskey protection for non-zero requesters and a settle gap.
module config_write_arbiter
    import cfg_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int W       = CFG_W,
    parameter int GAP     = 2,
    parameter int KEY_LSB = SYSKEY_LSB
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] wmask,
    input  logic [NREQ*W-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              busy,
    input  logic [W-1:0]      mem_dout,
    output logic              mem_wren,
    output logic [W-1:0]      mem_din
);

    localparam int IW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [W-1:0]    mask_q, mask_d, data_q, data_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic            err_q, err_d, busy_q, busy_d;
    logic [W-1:0]    din_q, din_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic [W-1:0]    mask_arr [NREQ];
    logic [W-1:0]    data_arr [NREQ];
    logic [W-1:0]    merged;
    logic            reject;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign mask_arr[i] = wmask[i*W +: W];
        assign data_arr[i] = wdata[i*W +: W];
    end

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign merged = (mem_dout & ~mask_q) | (data_q & mask_q);
    assign reject = (win_q != '0) && (mask_q[W-1:KEY_LSB] != '0);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        mask_d   = mask_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        din_d    = din_q;
        done_d   = '0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (arb_any) begin
                win_d   = arb_idx;
                mask_d  = mask_arr[arb_idx];
                data_d  = data_arr[arb_idx];
                gnt_d   = arb_gnt;
                state_d = ST_MERGE;
            end
            // Rejected and empty-mask writes skip the memory entirely.
            ST_MERGE: if (reject || mask_q == '0) begin
                state_d = ST_DONE;
                done_d  = gnt_q;
                err_d   = reject;
            end else begin
                din_d   = merged;
                state_d = ST_WRITE;
            end
            ST_WRITE: if (GAP == 0) begin
                state_d = ST_DONE;
                done_d  = gnt_q;
            end else begin
                cnt_d   = 4'(GAP - 1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: if (cnt_q == '0) begin
                state_d = ST_DONE;
                done_d  = gnt_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            ST_DONE: begin
                gnt_d    = '0;
                rr_ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            din_q    <= din_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign mem_din  = din_q;
    assign mem_wren = (state_q == ST_WRITE);

endmodule

// File: tb/tb_config_write_arbiter.sv
// Scoreboard bench: each transaction pushes expected grant/write/done events with cycle stamps.
module tb_config_write_arbiter;

    localparam int NREQ = 3;
    localparam int W    = 35;
    localparam int GAP  = 2;

    logic              clk = 1'b0;
    logic              arst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] wmask, wdata;
    logic [NREQ-1:0]   gnt, done;
    logic              err, busy, mem_wren;
    logic [W-1:0]      mem_din;
    logic [W-1:0]      mem = '0;
    logic              mem_load = 1'b0;
    logic [W-1:0]      mem_load_val = '0;
    int                cyc = 0;

    always #5 clk = ~clk;

    config_write_arbiter #(.NREQ(NREQ), .W(W), .GAP(GAP), .KEY_LSB(33)) dut (
        .clk      (clk),
        .arst     (arst),
        .req      (req),
        .wmask    (wmask),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .mem_dout (mem),
        .mem_wren (mem_wren),
        .mem_din  (mem_din)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_load) mem <= mem_load_val;
        else if (mem_wren) mem <= mem_din;
    end

    typedef struct {
        int           cyc;
        logic [W-1:0] val;
        logic         err;
    } exp_t;

    exp_t         gq[$], wq[$], dq[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] model_mem = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flag(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s at cycle %0d", tag, cyc);
    endtask

    task automatic expect_txn(input int idx, input int t, input logic [W-1:0] m,
                              input logic [W-1:0] d, input bit with_done);
        logic rej;
        exp_t e;
        rej   = (idx != 0) && (m[W-1:33] != 0);
        e.err = 1'b0;
        e.cyc = t + 1;
        e.val = W'(1 << idx);
        gq.push_back(e);
        if (!rej && m != 0) begin
            model_mem = (model_mem & ~m) | (d & m);
            e.cyc = t + 2;
            e.val = model_mem;
            wq.push_back(e);
        end
        if (with_done) begin
            e.cyc = (rej || m == 0) ? t + 2 : t + 3 + GAP;
            e.val = W'(1 << idx);
            e.err = rej;
            dq.push_back(e);
        end
    endtask

    task automatic set_slot(input int i, input logic [W-1:0] m, input logic [W-1:0] d);
        wmask[i*W +: W] = m;
        wdata[i*W +: W] = d;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done != 0) return;
        end
        flag({tag, "_timeout"});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wren"}, mem_wren, 0);
        check({tag, "_din"}, mem_din, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        arst = 1'b1;
        req  = '0;
        @(negedge clk);
        check_idle_outputs(tag);
        arst = 1'b0;
    endtask

    // Event monitor: every grant rise, write pulse and done pulse must match the queue head.
    initial begin
        logic [NREQ-1:0] pg;
        exp_t e;
        pg = '0;
        forever begin
            @(negedge clk);
            if (gnt != 0) check("gnt_onehot", 64'($onehot(gnt)), 1);
            if (gnt != 0 && pg == 0) begin
                if (gq.size() == 0) flag("unexpected_gnt");
                else begin
                    e = gq.pop_front();
                    check("gnt_cyc", cyc, e.cyc);
                    check("gnt_val", gnt, e.val[NREQ-1:0]);
                    check("gnt_busy", busy, 1);
                end
            end
            pg = gnt;
            if (mem_wren) begin
                if (wq.size() == 0) flag("unexpected_wren");
                else begin
                    e = wq.pop_front();
                    check("wr_cyc", cyc, e.cyc);
                    check("wr_din", mem_din, e.val);
                end
            end
            if (done != 0) begin
                if (dq.size() == 0) flag("unexpected_done");
                else begin
                    e = dq.pop_front();
                    check("done_cyc", cyc, e.cyc);
                    check("done_val", done, e.val[NREQ-1:0]);
                    check("done_err", err, e.err);
                end
            end
        end
    end

    initial begin
        int t;
        arst  = 1'b1;
        req   = '0;
        wmask = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        do_reset("rst0");

        // single write into an empty word
        @(negedge clk);
        set_slot(1, 35'h0000000FF, 35'h000000019);
        req = 3'b010;
        expect_txn(1, cyc, 35'h0000000FF, 35'h000000019, 1);
        wait_done("single");
        req = '0;

        // masked merge over an all-ones word
        @(negedge clk);
        mem_load = 1'b1;
        mem_load_val = 35'h7FFFFFFFF;
        model_mem = 35'h7FFFFFFFF;
        set_slot(2, 35'h0000F0000, 35'h000000000);
        req = 3'b100;
        expect_txn(2, cyc, 35'h0000F0000, 35'h000000000, 1);
        @(negedge clk);
        mem_load = 1'b0;
        wait_done("merge");
        req = '0;

        // syskey write from requester 1 is rejected, from requester 0 accepted
        @(negedge clk);
        set_slot(1, 35'h600000000, 35'h600000000);
        req = 3'b010;
        expect_txn(1, cyc, 35'h600000000, 35'h600000000, 1);
        wait_done("prot_rej");
        req = '0;
        @(negedge clk);
        set_slot(0, 35'h600000000, 35'h000000000);
        req = 3'b001;
        expect_txn(0, cyc, 35'h600000000, 35'h000000000, 1);
        wait_done("prot_ok");
        req = '0;

        // empty mask completes without a write or error
        @(negedge clk);
        set_slot(2, 35'h000000000, 35'h000001234);
        req = 3'b100;
        expect_txn(2, cyc, 35'h000000000, 35'h000001234, 1);
        wait_done("noop");
        req = '0;

        // request dropped after latch still completes
        @(negedge clk);
        set_slot(0, 35'h000F00000, 35'h000500000);
        req = 3'b001;
        expect_txn(0, cyc, 35'h000F00000, 35'h000500000, 1);
        repeat (2) @(negedge clk);
        req = '0;
        wait_done("drop");
        @(negedge clk);
        check("drop_busy", busy, 0);
        check("drop_gnt", gnt, 0);
        repeat (3) @(negedge clk);

        // round robin with all requests held from rr_ptr=0
        do_reset("rst_rr");
        @(negedge clk);
        set_slot(0, 35'h0000000FF, 35'h000000011);
        set_slot(1, 35'h00000FF00, 35'h000002200);
        set_slot(2, 35'h0000F0000, 35'h000030000);
        req = 3'b111;
        t = cyc;
        expect_txn(0, t,      35'h0000000FF, 35'h000000011, 1);
        expect_txn(1, t + 6,  35'h00000FF00, 35'h000002200, 1);
        expect_txn(2, t + 12, 35'h0000F0000, 35'h000030000, 1);
        expect_txn(0, t + 18, 35'h0000000FF, 35'h000000011, 1);
        repeat (4) wait_done("rr");
        req = '0;

        // leave rr_ptr at 2, then reset in the middle of a settle
        @(negedge clk);
        set_slot(1, 35'h00000FF00, 35'h00000AB00);
        req = 3'b010;
        expect_txn(1, cyc, 35'h00000FF00, 35'h00000AB00, 1);
        wait_done("pre_rst");
        req = '0;
        @(negedge clk);
        set_slot(2, 35'h00F000000, 35'h005000000);
        req = 3'b100;
        expect_txn(2, cyc, 35'h00F000000, 35'h005000000, 0);
        repeat (3) @(negedge clk);
        arst = 1'b1;
        req  = '0;
        @(negedge clk);
        check_idle_outputs("midrst");
        arst = 1'b0;
        set_slot(0, 35'h0000000FF, 35'h000000042);
        req = 3'b111;
        expect_txn(0, cyc, 35'h0000000FF, 35'h000000042, 1);
        wait_done("post_rst");
        req = '0;
        repeat (6) @(negedge clk);

        check("gq_left", gq.size(), 0);
        check("wq_left", wq.size(), 0);
        check("dq_left", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
